// File: rtl/mmcsr_axil_req_arbiter.sv
// Two-requester round-robin front end that sequences one AXI4-Lite read or write
// at a time on its master port and returns data/status to the granted requester.
module mmcsr_axil_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [1:0]                  req_valid,
    input  logic [1:0]                  req_we,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   req_wstrb,
    output logic [1:0]                  req_ready,
    output logic [1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [DATA_WIDTH-1:0]       m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]     m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                  state_r, state_s;
    logic                    grant_r, grant_s;
    logic                    last_grant_r;
    logic                    accept_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [STRB_WIDTH-1:0]   wstrb_r;
    logic                    aw_done_r, w_done_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    err_r;
    logic                    aw_fire_s, w_fire_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [STRB_WIDTH-1:0]   sel_wstrb_s;
    logic                    unused_bits_s;

    assign m_axi_awvalid = (state_r == ST_WR_REQ) && !aw_done_r;
    assign m_axi_wvalid  = (state_r == ST_WR_REQ) && !w_done_r;
    assign m_axi_bready  = (state_r == ST_WR_RESP);
    assign m_axi_arvalid = (state_r == ST_RD_REQ);
    assign m_axi_rready  = (state_r == ST_RD_RESP);
    assign m_axi_awaddr  = addr_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = wstrb_r;

    assign aw_fire_s = m_axi_awvalid && m_axi_awready;
    assign w_fire_s  = m_axi_wvalid && m_axi_wready;

    assign rsp_valid = (state_r == ST_DONE) ? (grant_r ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = (state_r == ST_DONE) ? rdata_r : {DATA_WIDTH{1'b0}};
    assign rsp_err   = (state_r == ST_DONE) && err_r;
    assign busy      = (state_r != ST_IDLE);
    assign req_ready = accept_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;

    assign sel_addr_s  = grant_s ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
    assign sel_wdata_s = grant_s ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
    assign sel_wstrb_s = grant_s ? req_wstrb[STRB_WIDTH +: STRB_WIDTH] : req_wstrb[0 +: STRB_WIDTH];

    // Byte-offset address bits and the OKAY/EXOKAY bit of resp carry no meaning here.
    assign unused_bits_s = ^{m_axi_bresp[0], m_axi_rresp[0], req_addr[1:0], req_addr[ADDR_WIDTH +: 2]};

    // Next-state, arbitration and accept decode.
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    accept_s = 1'b1;
                    // On contention the requester that did not win last time goes first.
                    if (req_valid == 2'b11) begin
                        grant_s = ~last_grant_r;
                    end else begin
                        grant_s = req_valid[1];
                    end
                    state_s = req_we[grant_s] ? ST_WR_REQ : ST_RD_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if ((aw_done_r || aw_fire_s) && (w_done_r || w_fire_s)) begin
                    state_s = ST_WR_RESP;
                end else begin
                    state_s = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                if (m_axi_arready) begin
                    state_s = ST_RD_RESP;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_RD_RESP: begin
                if (m_axi_rvalid) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RD_RESP;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, captured request payload, handshake flags and response registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            wdata_r      <= {DATA_WIDTH{1'b0}};
            wstrb_r      <= {STRB_WIDTH{1'b0}};
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            rdata_r      <= {DATA_WIDTH{1'b0}};
            err_r        <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                grant_r      <= grant_s;
                last_grant_r <= grant_s;
                addr_r       <= {sel_addr_s[ADDR_WIDTH-1:2], 2'b00};
                wdata_r      <= sel_wdata_s;
                wstrb_r      <= sel_wstrb_s;
                aw_done_r    <= 1'b0;
                w_done_r     <= 1'b0;
                rdata_r      <= {DATA_WIDTH{1'b0}};
                err_r        <= 1'b0;
            end else begin
                if (state_r == ST_WR_REQ) begin
                    aw_done_r <= aw_done_r || aw_fire_s;
                    w_done_r  <= w_done_r || w_fire_s;
                end
                if ((state_r == ST_WR_RESP) && m_axi_bvalid) begin
                    err_r <= m_axi_bresp[1];
                end
                if ((state_r == ST_RD_RESP) && m_axi_rvalid) begin
                    rdata_r <= m_axi_rdata;
                    err_r   <= m_axi_rresp[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_mmcsr_axil_req_arbiter.sv
// Directed-plus-random bench for mmcsr_axil_req_arbiter with a memory-backed
// AXI4-Lite slave and a transaction-level reference model.
module tb_mmcsr_axil_req_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [1:0]  req_valid, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err, busy;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    mmcsr_axil_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    int          aw_delay = 0, w_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    int          aw_cnt, w_cnt, b_count;
    logic        aw_pend, w_pend;
    logic [31:0] aw_addr_q, wd_q;
    logic [3:0]  ws_q;
    logic [31:0] smem [0:63];
    logic        aw_fire, w_fire, hs_aw, hs_w;
    logic [31:0] s_wa, s_wd;
    logic [3:0]  s_ws;

    assign aw_fire = m_axi_awvalid && m_axi_awready;
    assign w_fire  = m_axi_wvalid && m_axi_wready;
    assign hs_aw   = aw_pend || aw_fire;
    assign hs_w    = w_pend || w_fire;
    assign s_wa    = aw_fire ? m_axi_awaddr : aw_addr_q;
    assign s_wd    = w_fire ? m_axi_wdata : wd_q;
    assign s_ws    = w_fire ? m_axi_wstrb : ws_q;

    function automatic logic [31:0] slave_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_axi_awready <= 1'b0; m_axi_wready <= 1'b0; m_axi_arready <= 1'b0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
            m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= 32'h0;
            aw_cnt <= 0; w_cnt <= 0; aw_pend <= 1'b0; w_pend <= 1'b0;
            aw_addr_q <= 32'h0; wd_q <= 32'h0; ws_q <= 4'h0;
            for (int i = 0; i < 64; i++) smem[i] <= 32'h0;
        end else begin
            m_axi_arready <= 1'b1;
            if (aw_fire) begin
                aw_cnt <= 0; m_axi_awready <= (aw_delay == 0); aw_addr_q <= m_axi_awaddr;
            end else if (m_axi_awvalid) begin
                aw_cnt <= aw_cnt + 1; m_axi_awready <= (aw_cnt + 1 >= aw_delay);
            end else begin
                aw_cnt <= 0; m_axi_awready <= (aw_delay == 0);
            end
            if (w_fire) begin
                w_cnt <= 0; m_axi_wready <= (w_delay == 0); wd_q <= m_axi_wdata; ws_q <= m_axi_wstrb;
            end else if (m_axi_wvalid) begin
                w_cnt <= w_cnt + 1; m_axi_wready <= (w_cnt + 1 >= w_delay);
            end else begin
                w_cnt <= 0; m_axi_wready <= (w_delay == 0);
            end
            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0; b_count <= b_count + 1;
            end
            if (hs_aw && hs_w) begin
                m_axi_bvalid <= 1'b1; m_axi_bresp <= cfg_bresp;
                smem[s_wa[7:2]] <= slave_merge(smem[s_wa[7:2]], s_wd, s_ws);
                aw_pend <= 1'b0; w_pend <= 1'b0;
            end else begin
                aw_pend <= hs_aw; w_pend <= hs_w;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                m_axi_rvalid <= 1'b0;
            end else if (m_axi_arvalid && m_axi_arready && !m_axi_rvalid) begin
                m_axi_rvalid <= 1'b1; m_axi_rdata <= smem[m_axi_araddr[7:2]]; m_axi_rresp <= cfg_rresp;
            end
        end
    end

    // ---------------- reference model and checking ----------------
    int          n_checks = 0, n_fail = 0;
    int          exp_last = 1, acc_cyc = 0;
    logic [31:0] exp_rdata;
    logic [31:0] ref_mem [0:63];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        exp_last = 1;
    endtask

    task automatic model_accept(input int who, input bit we, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        exp_last = who;
        if (we) begin
            ref_mem[addr[7:2]] = (ref_mem[addr[7:2]] & ~mask) | (data & mask);
            exp_rdata = 32'h0;
        end else begin
            exp_rdata = ref_mem[addr[7:2]];
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {req_ready, rsp_valid, rsp_err, busy, m_axi_awvalid, m_axi_wvalid,
                               m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'h0);
        check({tag, "_awaddr"}, m_axi_awaddr, 64'h0);
        check({tag, "_araddr"}, m_axi_araddr, 64'h0);
        check({tag, "_wdata"}, {m_axi_wstrb, m_axi_wdata}, 64'h0);
        check({tag, "_rdata"}, rsp_rdata, 64'h0);
    endtask

    task automatic accept_wait(input logic [1:0] exp_grant);
        int n = 0;
        #1;
        while (req_ready == 2'b00 && n < 30) begin
            @(negedge ACLK); #1; n++;
        end
        check("accept_seen", req_ready != 2'b00, 64'h1);
        check("grant", req_ready, exp_grant);
        acc_cyc = cyc;
    endtask

    task automatic wait_rsp(input logic [1:0] exp_v, input int exp_lat, input bit exp_err);
        int n = 0;
        while (rsp_valid == 2'b00 && n < 50) begin
            @(negedge ACLK); n++;
        end
        check("rsp_seen", rsp_valid != 2'b00, 64'h1);
        check("rsp_latency", cyc - acc_cyc, exp_lat);
        check("rsp_valid", rsp_valid, exp_v);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        check("busy_done", busy, 64'h1);
        @(negedge ACLK);
        check("rsp_one_cycle", rsp_valid, 64'h0);
        check("busy_clear", busy, 64'h0);
    endtask

    task automatic issue(input int who, input bit we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        @(negedge ACLK);
        if (who == 0) begin
            req_addr[31:0] = addr; req_wdata[31:0] = data; req_wstrb[3:0] = strb;
        end else begin
            req_addr[63:32] = addr; req_wdata[63:32] = data; req_wstrb[7:4] = strb;
        end
        req_we[who] = we;
        req_valid[who] = 1'b1;
        accept_wait(who == 0 ? 2'b01 : 2'b10);
        model_accept(who, we, addr, data, strb);
        @(posedge ACLK); #1;
        req_valid[who] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int          who, g, prev_acc, bc;
        bit          we;
        logic [31:0] a, d;
        logic [3:0]  s;

        ARESETN = 1'b0;
        req_valid = 2'b00; req_we = 2'b00;
        req_addr = 64'h0; req_wdata = 64'h0; req_wstrb = 8'h0;
        model_reset();
        repeat (3) @(negedge ACLK);
        check_outputs_zero("reset");
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // Req0 zero-wait write.
        issue(0, 1'b1, 32'h0, 32'h0000_0001, 4'hF);
        @(negedge ACLK);
        check("c1_aw_w_valid", {m_axi_awvalid, m_axi_wvalid}, 64'h3);
        check("c1_awaddr", m_axi_awaddr, 64'h0);
        check("c1_wdata", m_axi_wdata, 64'h1);
        wait_rsp(2'b01, 3, 1'b0);

        // Req1 write then read back through an unaligned address.
        issue(1, 1'b1, 32'h4, 32'h0000_0002, 4'hF);
        wait_rsp(2'b10, 3, 1'b0);
        issue(1, 1'b0, 32'h5, 32'h0, 4'h0);
        @(negedge ACLK);
        check("c1_arvalid", m_axi_arvalid, 64'h1);
        check("araddr_aligned", m_axi_araddr, 64'h4);
        wait_rsp(2'b10, 3, 1'b0);
        check("read_back", exp_rdata, 64'h2);

        // Continuous contention: grants must alternate with back-to-back accepts.
        @(negedge ACLK);
        req_addr = {32'h40, 32'h40}; req_we = 2'b01;
        req_wdata[31:0] = $urandom; req_wstrb = 8'h0F;
        req_valid = 2'b11;
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            g = 1 - exp_last;
            accept_wait(g == 0 ? 2'b01 : 2'b10);
            if (k > 0) check("b2b_period", acc_cyc - prev_acc, 64'd4);
            prev_acc = acc_cyc;
            model_accept(g, g == 0, 32'h40, req_wdata[31:0], 4'hF);
            @(negedge ACLK);
            if (g == 0) req_wdata[31:0] = $urandom;
            wait_rsp(g == 0 ? 2'b01 : 2'b10, 3, 1'b0);
        end
        req_valid = 2'b00;

        // Slow AW channel with an immediate W channel.
        aw_delay = 3;
        repeat (2) @(negedge ACLK);
        bc = b_count;
        issue(0, 1'b1, 32'h20, $urandom, 4'hF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge ACLK);
            check("slow_awvalid", m_axi_awvalid, (i <= 4) ? 64'h1 : 64'h0);
            check("slow_wvalid", m_axi_wvalid, (i == 1) ? 64'h1 : 64'h0);
        end
        wait_rsp(2'b01, 6, 1'b0);
        check("single_b", b_count - bc, 64'h1);
        aw_delay = 0;
        repeat (2) @(negedge ACLK);

        // Error responses on both channels.
        cfg_rresp = 2'b10;
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(2'b10, 3, 1'b1);
        cfg_rresp = 2'b00;
        cfg_bresp = 2'b11;
        issue(0, 1'b1, 32'h24, $urandom, 4'h3);
        wait_rsp(2'b01, 3, 1'b1);
        cfg_bresp = 2'b00;

        // Reset while waiting for the write response.
        issue(0, 1'b1, 32'h30, $urandom, 4'hF);
        @(negedge ACLK);
        @(negedge ACLK);
        check("in_wr_resp", m_axi_bready, 64'h1);
        ARESETN = 1'b0;
        #1;
        check_outputs_zero("midreset");
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check("no_rsp_after_reset", rsp_valid, 64'h0);
        end
        req_addr = {32'h4, 32'h30}; req_we = 2'b00; req_valid = 2'b11;
        accept_wait(2'b01);
        model_accept(0, 1'b0, 32'h30, 32'h0, 4'h0);
        @(negedge ACLK);
        req_valid = 2'b00;
        wait_rsp(2'b01, 3, 1'b0);

        // Random single-requester traffic, including zero strobes.
        for (int t = 0; t < 12; t++) begin
            who = $urandom_range(0, 1);
            we  = 1'($urandom_range(0, 1));
            a   = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            if (t == 0) begin
                we = 1'b1; s = 4'h0;
            end
            issue(who, we, a, d, s);
            @(negedge ACLK);
            if (we) begin
                check("rnd_awaddr", m_axi_awaddr, {a[31:2], 2'b00});
                check("rnd_wstrb", m_axi_wstrb, s);
                check("rnd_wdata", m_axi_wdata, d);
            end else begin
                check("rnd_araddr", m_axi_araddr, {a[31:2], 2'b00});
            end
            wait_rsp(who == 0 ? 2'b01 : 2'b10, 3, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmcsr_axil_req_arbiter.md
Name: mmcsr_axil_req_arbiter

Overview:
Two-requester front end for the memory-mapped CSR AXI4-Lite slave. It accepts simple single-word read/write requests from two internal requesters (req 0: core CSR unit, req 1: debug module). It arbitrates between them round-robin and sequences exactly one AXI4-Lite transaction at a time on its master port. It returns read data or write completion, plus error status, to the granted requester.

Parameters:
ADDR_WIDTH, 32, AXI4-Lite and requester address width
DATA_WIDTH, 32, data width; only 32 supported, wstrb width = DATA_WIDTH/8

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid, bit i = requester i
req_we  in  2  1 = write, 0 = read
req_addr  in  2*ADDR_WIDTH  byte address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  2*DATA_WIDTH  write data, packed as req_addr
req_wstrb  in  2*DATA_WIDTH/8  byte strobes, packed as req_addr
req_ready  out  2  one-hot one-cycle accept pulse
rsp_valid  out  2  one-hot one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for writes
rsp_err  out  1  1 if AXI resp[1]=1 (SLVERR/DECERR), valid with rsp_valid
busy  out  1  1 from accept until the cycle after rsp_valid
m_axi_awaddr  out  ADDR_WIDTH  write address, bits [1:0] forced 0
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_WIDTH  write data
m_axi_wstrb  out  DATA_WIDTH/8  write strobes
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  ADDR_WIDTH  read address, bits [1:0] forced 0
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset (ARESETN low, async): all outputs 0; FSM=IDLE; last_grant=1, so requester 0 wins the first contention.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: if any req_valid, grant = requester i (if both valid, the one != last_grant). Same cycle: req_ready[i]=1 (combinational from registered state plus req_valid); capture addr/wdata/wstrb/we; update last_grant. Next state WR_REQ or RD_REQ.
- WR_REQ: awvalid and wvalid rise the cycle after accept, together. Each drops the cycle after its own handshake (valid&ready); flags aw_done/w_done track this. When both are done (possibly in the same cycle), go to WR_RESP. Never deassert valid before its handshake; payload stable while valid.
- WR_RESP: bready=1. On bvalid, capture err=bresp[1] and go to DONE.
- RD_REQ: arvalid=1 until arready, then RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata and err=rresp[1], go to DONE.
- DONE: rsp_valid[grant]=1 for exactly one cycle with rsp_rdata/rsp_err, then IDLE. busy clears the following cycle.
- Minimum latency, zero-wait slave: accept C0, AW/W or AR valid C1, B/R handshake C2, rsp_valid C3, next accept C4.
- One transaction in flight; no outstanding overlap. req_valid of the waiting requester is held, never dropped by the block.
- wstrb=0 is still issued on AXI unchanged.
- Reset mid-transaction aborts immediately; no response is delivered. The slave is reset by the same ARESETN.
- A requester may drop req_valid before accept; no state is retained for it.

Test Plan:
- Req0 write addr 0x0, data 0x00000001, strb 0xF, zero-wait slave -> awvalid/wvalid at C1, rsp_valid=2'b01 at C3, rsp_err=0.
- Req1 read 0x4 after write of 0x00000002 -> rsp_rdata=0x00000002, rsp_valid=2'b10; addr 0x5 issues araddr=0x4.
- Both requesters valid continuously for 4 transactions -> grants alternate 0,1,0,1; req_ready never both high.
- Slave delays awready by 3 cycles and wready by 0 -> wvalid drops after C1, awvalid held to the C4 handshake, single B accepted, one rsp_valid.
- Slave returns rresp=2'b10 -> rsp_err=1; bresp=2'b11 -> rsp_err=1.
- ARESETN low during WR_RESP -> all outputs 0 asynchronously, no rsp_valid; after release, req0 wins contention.
